// File: rtl/a_wr_pingpong_x2_ram_pkg.sv
// Shared constants and types for the ping-pong write controller.
// DATA_W  : width of one data word written into either RAM bank.
// state_e : write-side FSM states (FILL accepts words, STALL drops them).
package a_wr_pingpong_x2_ram_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/a_wr_pingpong_x2_ram_if.sv
// Bus bundle between the word source/bank reader and the ping-pong
// write controller.
//   data_i, dv_i       : incoming word and its one-cycle valid
//   rd_done_i          : reader finished with bank ctrl_o
//   data_o_*, addr_o_*, we_o_* : write port of RAM 0 / RAM 1
//   ctrl_o             : bank the reader consumes next (read crossbar select)
//   bank_rdy_o         : bank ctrl_o is full and readable
//   ovf_o              : sticky, a word was dropped
// master = source/reader side, slave = controller side.
interface a_wr_pingpong_x2_ram_if
  import a_wr_pingpong_x2_ram_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic [DATA_W-1:0] data_i;
  logic              dv_i;
  logic              rd_done_i;
  logic [DATA_W-1:0] data_o_0;
  logic [DATA_W-1:0] data_o_1;
  logic [ADDR_W-1:0] addr_o_0;
  logic [ADDR_W-1:0] addr_o_1;
  logic              we_o_0;
  logic              we_o_1;
  logic              ctrl_o;
  logic              bank_rdy_o;
  logic              ovf_o;

  modport master (
    output data_i, dv_i, rd_done_i,
    input  data_o_0, data_o_1, addr_o_0, addr_o_1, we_o_0, we_o_1,
    input  ctrl_o, bank_rdy_o, ovf_o
  );

  modport slave (
    input  data_i, dv_i, rd_done_i,
    output data_o_0, data_o_1, addr_o_0, addr_o_1, we_o_0, we_o_1,
    output ctrl_o, bank_rdy_o, ovf_o
  );

endinterface

// File: rtl/a_wr_pingpong_x2_ram.sv
// Ping-pong write controller for two RAM banks of DEPTH words each.
// Incoming words fill one bank while the reader drains the other; banks
// are handed to the reader strictly in fill order (0,1,0,1,...).  When
// both banks are full the controller stalls and drops words (sticky ovf).
// Ports:
//   clk_i : single clock, all state changes on its rising edge
//   rst_i : asynchronous active-high reset
//   bus   : slave side of a_wr_pingpong_x2_ram_if (see interface header)
module a_wr_pingpong_x2_ram
  import a_wr_pingpong_x2_ram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  a_wr_pingpong_x2_ram_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_r, state_s;
  logic              wsel_r, wsel_s;
  logic [ADDR_W-1:0] wcnt_r, wcnt_s;
  logic [1:0]        full_r, full_s;
  logic              rsel_r, rsel_s;
  logic              write_s;
  logic              rd_ok_s;

  logic              we0_r, we1_r;
  logic [DATA_W-1:0] data0_r, data1_r;
  logic [ADDR_W-1:0] addr0_r, addr1_r;
  logic              rdy_r;
  logic              ovf_r;

  // Next-state logic: reader release first, then the write side so that a
  // final write in the same cycle sees the freshly freed bank.
  always_comb begin
    state_s = state_r;
    wsel_s  = wsel_r;
    wcnt_s  = wcnt_r;
    full_s  = full_r;
    rsel_s  = rsel_r;
    write_s = 1'b0;
    rd_ok_s = bus.rd_done_i & full_r[rsel_r];

    if (rd_ok_s) begin
      full_s[rsel_r] = 1'b0;
      rsel_s         = ~rsel_r;
    end else begin
      rsel_s = rsel_r;
    end

    case (state_r)
      ST_FILL: begin
        write_s = bus.dv_i;
        if (bus.dv_i) begin
          // DEPTH is a power of two, so the increment wraps to 0 by itself
          wcnt_s = wcnt_r + ADDR_W'(1);
          if (wcnt_r == LAST_ADDR) begin
            full_s[wsel_r] = 1'b1;
            if (!full_s[~wsel_r]) begin
              wsel_s  = ~wsel_r;
              state_s = ST_FILL;
            end else begin
              state_s = ST_STALL;
            end
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          wcnt_s = wcnt_r;
        end
      end
      ST_STALL: begin
        // resume into whichever bank the reader just released
        if (rd_ok_s) begin
          wsel_s  = rsel_r;
          state_s = ST_FILL;
        end else begin
          state_s = ST_STALL;
        end
      end
      default: begin
        state_s = ST_FILL;
      end
    endcase
  end

  // State and registered RAM-side outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_FILL;
      wsel_r  <= 1'b0;
      wcnt_r  <= {ADDR_W{1'b0}};
      full_r  <= 2'b00;
      rsel_r  <= 1'b0;
      we0_r   <= 1'b0;
      we1_r   <= 1'b0;
      data0_r <= {DATA_W{1'b0}};
      data1_r <= {DATA_W{1'b0}};
      addr0_r <= {ADDR_W{1'b0}};
      addr1_r <= {ADDR_W{1'b0}};
      rdy_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      wsel_r  <= wsel_s;
      wcnt_r  <= wcnt_s;
      full_r  <= full_s;
      rsel_r  <= rsel_s;
      we0_r   <= write_s & ~wsel_r;
      we1_r   <= write_s & wsel_r;
      // the idle bank keeps its last data/address
      if (write_s && !wsel_r) begin
        data0_r <= bus.data_i;
        addr0_r <= wcnt_r;
      end
      if (write_s && wsel_r) begin
        data1_r <= bus.data_i;
        addr1_r <= wcnt_r;
      end
      // registered copy of full[rsel] built from the next-state values
      rdy_r   <= full_s[rsel_s];
      ovf_r   <= ovf_r | (bus.dv_i & (state_r == ST_STALL));
    end
  end

  assign bus.we_o_0     = we0_r;
  assign bus.we_o_1     = we1_r;
  assign bus.data_o_0   = data0_r;
  assign bus.data_o_1   = data1_r;
  assign bus.addr_o_0   = addr0_r;
  assign bus.addr_o_1   = addr1_r;
  assign bus.ctrl_o     = rsel_r;
  assign bus.bank_rdy_o = rdy_r;
  assign bus.ovf_o      = ovf_r;

endmodule

// File: tb/tb_a_wr_pingpong_x2_ram.sv
// Self-checking bench for a_wr_pingpong_x2_ram with DEPTH=4.
// A queue-based model of the two banks predicts every output each cycle.
module tb_a_wr_pingpong_x2_ram;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  a_wr_pingpong_x2_ram_if #(.ADDR_W(ADDR_W)) bus ();

  a_wr_pingpong_x2_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  int          m_wbank;
  int          m_wcnt;
  int          m_reads;
  int          m_q[$];      // full banks, oldest first
  bit          m_stall;
  bit          m_ovf;
  bit          m_we[2];
  logic [15:0] m_data[2];
  logic [1:0]  m_addr[2];

  task automatic model_reset();
    m_wbank = 0; m_wcnt = 0; m_reads = 0; m_stall = 1'b0; m_ovf = 1'b0;
    m_q.delete();
    for (int b = 0; b < 2; b++) begin
      m_we[b] = 1'b0; m_data[b] = 16'h0000; m_addr[b] = 2'b00;
    end
  endtask

  task automatic model_step(input bit dv, input logic [15:0] d, input bit rd);
    bit rd_ok;
    int freed;
    rd_ok = rd && (m_q.size() > 0);
    freed = 0;
    m_we[0] = 1'b0;
    m_we[1] = 1'b0;
    if (rd_ok) begin
      freed = m_q.pop_front();
      m_reads++;
    end
    if (m_stall) begin
      if (dv) m_ovf = 1'b1;
      if (rd_ok) begin
        m_stall = 1'b0;
        m_wbank = freed;
      end
    end else if (dv) begin
      m_we[m_wbank]   = 1'b1;
      m_data[m_wbank] = d;
      m_addr[m_wbank] = m_wcnt[1:0];
      m_wcnt++;
      if (m_wcnt == DEPTH) begin
        m_wcnt = 0;
        m_q.push_back(m_wbank);
        if (m_q.size() == 1) m_wbank = 1 - m_wbank;
        else m_stall = 1'b1;
      end
    end
  endtask

  function automatic logic [40:0] obs();
    return {bus.we_o_0, bus.we_o_1, bus.data_o_0, bus.data_o_1,
            bus.addr_o_0, bus.addr_o_1, bus.ctrl_o, bus.bank_rdy_o, bus.ovf_o};
  endfunction

  function automatic logic [40:0] expv();
    logic rdy;
    rdy = (m_q.size() > 0);
    return {m_we[0], m_we[1], m_data[0], m_data[1],
            m_addr[0], m_addr[1], m_reads[0], rdy, m_ovf};
  endfunction

  // ---------------- stimulus helpers ----------------
  // One clock: inputs at negedge, model stepped at posedge, outputs ready at next negedge.
  task automatic drive(input bit dv, input logic [15:0] d, input bit rd);
    bus.dv_i = dv; bus.data_i = d; bus.rd_done_i = rd;
    @(posedge clk);
    model_step(dv, d, rd);
    @(negedge clk);
    bus.dv_i = 1'b0; bus.rd_done_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; bus.dv_i = 1'b0; bus.rd_done_i = 1'b0; bus.data_i = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs() !== 41'd0) begin
      n_errors++; $display("FAIL reset_state: got %h expected %h", obs(), 41'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_rd_ignored();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0000, 1'b1);
      n_checks++;
      if ({bus.ctrl_o, bus.bank_rdy_o} !== 2'b00 || obs() !== expv()) begin
        n_errors++; $display("FAIL rd_ignored: got %h expected %h", obs(), expv());
      end
    end
  endtask

  task automatic test_fill_bank0();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      n_checks++;
      if (obs() !== expv() || bus.we_o_0 !== 1'b1 || bus.addr_o_0 !== 2'(i - 1)) begin
        n_errors++; $display("FAIL fill_bank0 word %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_checks++;
    if ({bus.bank_rdy_o, bus.ctrl_o} !== 2'b10) begin
      n_errors++; $display("FAIL bank0_ready: got %b expected 10", {bus.bank_rdy_o, bus.ctrl_o});
    end
  endtask

  task automatic test_stall();
    for (int i = 5; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b0);
      n_checks++;
      if (obs() !== expv() || bus.we_o_1 !== 1'b1 || bus.addr_o_1 !== 2'(i - 5)) begin
        n_errors++; $display("FAIL fill_bank1 word %0d: got %h expected %h", i, obs(), expv());
      end
    end
    drive(1'b1, 16'h0009, 1'b0);
    n_checks++;
    if ({bus.we_o_0, bus.we_o_1, bus.ovf_o} !== 3'b001 || obs() !== expv()) begin
      n_errors++; $display("FAIL stall_drop: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_release();
    drive(1'b0, 16'h0000, 1'b1);
    n_checks++;
    if ({bus.ctrl_o, bus.bank_rdy_o} !== 2'b11 || obs() !== expv()) begin
      n_errors++; $display("FAIL release: got %h expected %h", obs(), expv());
    end
    drive(1'b1, 16'h00AA, 1'b0);
    n_checks++;
    if ({bus.we_o_0, bus.addr_o_0, bus.data_o_0} !== {1'b1, 2'b00, 16'h00AA} || obs() !== expv()) begin
      n_errors++; $display("FAIL after_release_write: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_errors++; $display("FAIL simul_prefill %0d: got %h expected %h", i, obs(), expv());
      end
    end
    drive(1'b1, 16'h0107, 1'b1);
    n_checks++;
    if ({bus.we_o_1, bus.addr_o_1, bus.ctrl_o, bus.bank_rdy_o, bus.ovf_o} !== {1'b1, 2'b11, 1'b1, 1'b1, 1'b0}
        || obs() !== expv()) begin
      n_errors++; $display("FAIL simul_final: got %h expected %h", obs(), expv());
    end
    drive(1'b1, 16'h0BEE, 1'b0);
    n_checks++;
    if ({bus.we_o_0, bus.addr_o_0, bus.data_o_0, bus.ctrl_o, bus.ovf_o} !== {1'b1, 2'b00, 16'h0BEE, 1'b1, 1'b0}
        || obs() !== expv()) begin
      n_errors++; $display("FAIL simul_next: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2222, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs() !== 41'd0) begin
      n_errors++; $display("FAIL async_reset: got %h expected %h", obs(), 41'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'h0055, 1'b0);
    n_checks++;
    if ({bus.we_o_0, bus.addr_o_0, bus.data_o_0} !== {1'b1, 2'b00, 16'h0055} || obs() !== expv()) begin
      n_errors++; $display("FAIL post_reset_write: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    bit          dv, rd;
    logic [15:0] d;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      dv = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 2);
      d  = 16'($urandom);
      drive(dv, d, rd);
      n_checks++;
      if (obs() !== expv() || (bus.we_o_0 && bus.we_o_1)) begin
        n_errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rd_ignored();
    test_fill_bank0();
    test_stall();
    test_release();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/a_wr_pingpong_x2_ram.md
A_WR_PINGPONG_X2_RAM -- requirements
Module: a_wr_pingpong_x2_ram

Interface
REQ-001 Parameter: DEPTH, default 256, number of words per bank; SHALL be a power of two and at least 2.
REQ-002 Parameter: ADDR_W, default 8, bank address width; SHALL equal log2(DEPTH).
REQ-003 Port: clk_i, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 Port: rst_i, input, 1, reset; asynchronous, active-high.
REQ-005 Port: data_i, input, 16, write data word.
REQ-006 Port: dv_i, input, 1, data_i valid for one cycle.
REQ-007 Port: rd_done_i, input, 1, one-cycle pulse; the reader has finished consuming bank ctrl_o.
REQ-008 Port: data_o_0 / data_o_1, output, 16 each, write data to RAM 0 / RAM 1.
REQ-009 Port: addr_o_0 / addr_o_1, output, ADDR_W each, write address to RAM 0 / RAM 1.
REQ-010 Port: we_o_0 / we_o_1, output, 1 each, write enable to RAM 0 / RAM 1.
REQ-011 Port: ctrl_o, output, 1, bank the reader reads next; drives the read crossbar select.
REQ-012 Port: bank_rdy_o, output, 1, bank ctrl_o is full and readable.
REQ-013 Port: ovf_o, output, 1, sticky flag; a dv_i word was dropped.

Function
REQ-014 Internal state SHALL comprise: wsel (bank being written), wcnt (ADDR_W bits), full[1:0], rsel (drives ctrl_o) and FSM state in {FILL, STALL}.
REQ-015 In FILL with dv_i=1, the block SHALL register exactly one write: on the next cycle we_o_<wsel>=1, data_o_<wsel>=data_i, addr_o_<wsel>=wcnt; wcnt then increments. Write latency is 1 cycle.
REQ-016 we_o of the non-selected bank SHALL be 0; its data and address outputs SHALL hold their last values. Both bank write enables SHALL never be high in the same cycle.
REQ-017 A write at wcnt=DEPTH-1 SHALL, in the same cycle: set full[wsel]; wrap wcnt to 0; switch wsel to the other bank if that bank is not full (stay in FILL), otherwise enter STALL.
REQ-018 In STALL, dv_i words SHALL be dropped, no we_o SHALL assert, and ovf_o SHALL be set and held until reset.
REQ-019 bank_rdy_o SHALL equal full[rsel].
REQ-020 rd_done_i while bank_rdy_o=1 SHALL clear full[rsel] and toggle rsel on the next edge. rd_done_i while bank_rdy_o=0 SHALL be ignored.
REQ-021 In STALL, a valid rd_done_i SHALL set wsel to the freed bank and return to FILL on the next edge. A dv_i in that same cycle SHALL be dropped and counted as overflow.
REQ-022 Simultaneous final write (wcnt=DEPTH-1) into bank b and valid rd_done_i freeing bank !b: the block SHALL take FILL with wsel=!b, set full[b], clear full[!b], and toggle rsel to b.
REQ-023 Words SHALL be written in arrival order; banks SHALL be presented to the reader in fill order (0,1,0,1,...).

Reset
REQ-024 While rst_i=1, the block SHALL hold: we_o_0=we_o_1=0, data_o_0=data_o_1=0, addr_o_0=addr_o_1=0, wsel=0, wcnt=0, full=2'b00, rsel=0 (ctrl_o=0), bank_rdy_o=0, ovf_o=0, state FILL.
REQ-025 Reset asserted mid-bank SHALL discard all partial and full bank status; after release the first accepted word SHALL go to RAM 0, address 0.

Structure
REQ-026 The FSM state encoding and the 16-bit data width constant SHALL be placed in the shared emulation control package; DEPTH and ADDR_W remain module parameters.
REQ-027 The block SHALL be flat, with no sub-modules. It pairs with the existing 2-to-1 read crossbar: ctrl_o connects to that crossbar's ctrl_i.

Verification (DEPTH=4)
REQ-028 Reset, then 4 words 0x0001..0x0004 -> we_o_0 pulses at addr 0..3 one cycle after each dv_i; bank_rdy_o=1 and ctrl_o=0 after the 4th; wsel=1.
REQ-029 8 consecutive words, no rd_done_i -> words 5..8 land in RAM 1 addr 0..3; a 9th word is dropped; ovf_o=1; no we_o asserts.
REQ-030 From the REQ-029 end state, pulse rd_done_i -> ctrl_o=1, bank_rdy_o=1; the next word 0x00AA is written to RAM 0 addr 0.
REQ-031 Bank 1 at wcnt=3 and bank 0 full; pulse rd_done_i with the final dv_i -> no stall; next word goes to RAM 0 addr 0; ctrl_o=1; ovf_o stays 0.
REQ-032 Assert rst_i asynchronously after 2 words -> all outputs go to reset values immediately; after release, word 0x0055 is written to RAM 0 addr 0.
REQ-033 rd_done_i pulsed with bank_rdy_o=0 -> no change to ctrl_o or full.
